load_scoreboard_stall_unit: RTL and testbench

- Parametrised successor to the single-cycle load-interlock stall unit.
- Sits between decode and execute and detects load-use hazards for loads whose data arrives LOAD_LAT cycles after EX, using a per-register countdown scoreboard.
- Also applies taken-branch flush with priority over stall.
- Counts stall cycles and raises a sticky watchdog flag on a stall run longer than any legal load could cause.

---
 rtl/load_scoreboard_stall_unit_pkg.sv | 26 ++
 rtl/load_scoreboard_stall_unit_if.sv | 32 +++
 rtl/load_scoreboard_stall_unit_reg_scoreboard.sv | 39 +++
 rtl/load_scoreboard_stall_unit.sv | 83 ++++++++
 tb/tb_load_scoreboard_stall_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_scoreboard_stall_unit_pkg.sv
// load_scoreboard_stall_unit_pkg: instruction-type encoding and source-register usage shared by decode,
// forwarding and the load stall unit.
package load_scoreboard_stall_unit_pkg;

    typedef enum logic [2:0] {
        IT_RR_ALU   = 3'd0,
        IT_ALU_IMM  = 3'd1,
        IT_LOAD     = 3'd2,
        IT_STORE    = 3'd3,
        IT_BRANCH   = 3'd4,
        IT_PP_MOVE  = 3'd5,
        IT_PP_HMOVE = 3'd6,
        IT_PP_VMOVE = 3'd7
    } instr_t;

    typedef struct packed {
        logic uses_rs;
        logic uses_rt;
    } src_use_t;

    // Every type reads RS; only register-register ALU, store and branch also read RT.
    function automatic src_use_t src_use(input instr_t t);
        return '{uses_rs: 1'b1, uses_rt: (t == IT_RR_ALU || t == IT_STORE || t == IT_BRANCH)};
    endfunction

endpackage

// File: rtl/load_scoreboard_stall_unit_if.sv
// load_scoreboard_stall_unit_if: decode/execute hazard bus between the pipeline and the stall unit.
//   master: pipeline side, drives DEC/EX instruction info, receives enables/flushes and stall stats.
//   slave : stall unit side.
interface load_scoreboard_stall_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [2:0]       decInstrType;
    logic [REG_W-1:0] decRS;
    logic [REG_W-1:0] decRT;
    logic [2:0]       exInstrType;
    logic [REG_W-1:0] exRegDest;
    logic             exValid;
    logic             exBranchTaken;
    logic             enPC;
    logic             enIfId;
    logic             rstIfId;
    logic             rstIdEx;
    logic [CNT_W-1:0] stallCount;
    logic             stallErr;

    modport master (
        output decInstrType, decRS, decRT, exInstrType, exRegDest, exValid, exBranchTaken,
        input  enPC, enIfId, rstIfId, rstIdEx, stallCount, stallErr
    );

    modport slave (
        input  decInstrType, decRS, decRT, exInstrType, exRegDest, exValid, exBranchTaken,
        output enPC, enIfId, rstIfId, rstIdEx, stallCount, stallErr
    );

endinterface

// File: rtl/load_scoreboard_stall_unit_reg_scoreboard.sv
// reg_scoreboard: per-register countdown of cycles until a loaded value is usable.
//   clk, rst          : clock, synchronous active-high clear
//   i_set, i_set_idx  : start a countdown of LOAD_LAT-1 on a register (wins over decrement)
//   i_rd_idx_a/b      : query ports
//   o_busy_a/b        : register still counting down
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set,
    input  logic [IDX_W-1:0] i_set_idx,
    input  logic [IDX_W-1:0] i_rd_idx_a,
    input  logic [IDX_W-1:0] i_rd_idx_b,
    output logic             o_busy_a,
    output logic             o_busy_b
);
    localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW-1:0] INIT = CW'(LOAD_LAT - 1);

    logic [CW-1:0] r_cnt [NUM_REGS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst)
                r_cnt[i] <= '0;
            else if (i_set && i_set_idx == IDX_W'(i))
                r_cnt[i] <= INIT;
            else if (r_cnt[i] != '0)
                r_cnt[i] <= r_cnt[i] - CW'(1);
        end
    end

    assign o_busy_a = r_cnt[i_rd_idx_a] != '0;
    assign o_busy_b = r_cnt[i_rd_idx_b] != '0;

endmodule

// File: rtl/load_scoreboard_stall_unit.sv
// load_scoreboard_stall_unit: load-use interlock for multi-cycle load latency, with branch flush priority,
// saturating stall counter and sticky watchdog.
//   clk, rst : clock, synchronous active-high reset (forces a full flush while held)
//   bus      : slave side of the hazard bus (DEC/EX info in; enPC, enIfId, rstIfId, rstIdEx,
//              stallCount, stallErr out)
module load_scoreboard_stall_unit
    import load_scoreboard_stall_unit_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    load_scoreboard_stall_unit_if.slave    bus
);
    // Run counter saturates one past LOAD_LAT, which is all the watchdog needs to see.
    localparam int RUN_W = $clog2(LOAD_LAT + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOAD_LAT + 1);

    logic             w_ex_load;
    logic             w_busy_rs;
    logic             w_busy_rt;
    logic             w_haz_rs;
    logic             w_haz_rt;
    logic             w_stall;
    logic             w_apply;
    src_use_t         w_use;
    logic [CNT_W-1:0] r_cnt;
    logic [RUN_W-1:0] r_run;
    logic             r_err;

    // A load writing r0 is never tracked when r0 is hardwired, so r0 can never look busy.
    assign w_ex_load = bus.exValid && instr_t'(bus.exInstrType) == IT_LOAD &&
                       !(ZERO_REG != 0 && bus.exRegDest == '0);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LOAD_LAT (LOAD_LAT),
        .IDX_W    (REG_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set      (w_ex_load),
        .i_set_idx  (bus.exRegDest),
        .i_rd_idx_a (bus.decRS),
        .i_rd_idx_b (bus.decRT),
        .o_busy_a   (w_busy_rs),
        .o_busy_b   (w_busy_rt)
    );

    // The load currently in EX is not in the scoreboard yet, so it is matched directly.
    assign w_haz_rs = (w_ex_load && bus.exRegDest == bus.decRS) || w_busy_rs;
    assign w_haz_rt = (w_ex_load && bus.exRegDest == bus.decRT) || w_busy_rt;
    assign w_use    = src_use(instr_t'(bus.decInstrType));
    assign w_stall  = (w_use.uses_rs && w_haz_rs) || (w_use.uses_rt && w_haz_rt);
    assign w_apply  = !rst && !bus.exBranchTaken && w_stall;

    assign bus.enPC       = !rst && !w_apply;
    assign bus.enIfId     = !rst && !w_apply;
    assign bus.rstIfId    = rst || bus.exBranchTaken;
    assign bus.rstIdEx    = rst || bus.exBranchTaken || w_stall;
    assign bus.stallCount = r_cnt;
    assign bus.stallErr   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_run <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_apply && r_cnt != '1)
                r_cnt <= r_cnt + CNT_W'(1);
            r_run <= w_apply ? ((r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1)) : '0;
            // This stall cycle makes the run longer than any single load can justify.
            if (w_apply && r_run >= RUN_W'(LOAD_LAT))
                r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_scoreboard_stall_unit.sv
// tb_load_scoreboard_stall_unit: four stall-unit configurations driven in lockstep and checked against a
// cycle-level model plus hand-computed expectations.
module tb_load_scoreboard_stall_unit;

    localparam int NI = 4;

    // Instance configurations: 0 LL1/zero-reg, 1 LL3, 2 LL4, 3 LL1/no zero-reg/4-bit counter.
    function automatic int ll_of(int i);
        return (i == 1) ? 3 : (i == 2) ? 4 : 1;
    endfunction
    function automatic int zr_of(int i);
        return (i == 3) ? 0 : 1;
    endfunction
    function automatic int cw_of(int i);
        return (i == 3) ? 4 : 16;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] decInstrType = 3'd1;
    logic [4:0] decRS = '0;
    logic [4:0] decRT = '0;
    logic [2:0] exInstrType = 3'd0;
    logic [4:0] exRegDest = '0;
    logic       exValid = 1'b0;
    logic       exBranchTaken = 1'b0;

    logic [3:0]  ctl [NI];
    logic [15:0] cnt [NI];
    logic        err [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = ll_of(g);
        localparam int Z = zr_of(g);
        localparam int C = cw_of(g);
        load_scoreboard_stall_unit_if #(.REG_W(5), .CNT_W(C)) bus ();
        assign bus.decInstrType  = decInstrType;
        assign bus.decRS         = decRS;
        assign bus.decRT         = decRT;
        assign bus.exInstrType   = exInstrType;
        assign bus.exRegDest     = exRegDest;
        assign bus.exValid       = exValid;
        assign bus.exBranchTaken = exBranchTaken;
        load_scoreboard_stall_unit #(
            .REG_W    (5),
            .NUM_REGS (32),
            .LOAD_LAT (L),
            .ZERO_REG (Z),
            .CNT_W    (C)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign ctl[g] = {bus.enPC, bus.enIfId, bus.rstIfId, bus.rstIdEx};
        assign cnt[g] = 16'(bus.stallCount);
        assign err[g] = bus.stallErr;
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(string nm, int i, logic [3:0] exp);
        chk(nm, 16'(ctl[i]), 16'(exp));
    endtask
    task automatic chk_cnt(string nm, int i, logic [15:0] exp);
        chk(nm, cnt[i], exp);
    endtask
    task automatic chk_err(string nm, int i, logic exp);
        chk(nm, 16'(err[i]), 16'(exp));
    endtask

    // Model: each register has an absolute cycle from which its loaded value may be read in DEC.
    longint avail [NI][32];
    int     m_cnt [NI];
    int     m_run [NI];
    bit     m_err [NI];
    longint cyc   = 0;
    bit     armed = 0;

    function automatic bit uses_rt(logic [2:0] t);
        return t == 3'd0 || t == 3'd3 || t == 3'd4;
    endfunction

    function automatic bit m_haz(int i, logic [4:0] s);
        if (zr_of(i) != 0 && s == 5'd0) return 1'b0;
        if (exValid && exInstrType == 3'd2 && exRegDest == s) return 1'b1;
        return cyc < avail[i][s];
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit         st;
            logic [3:0] ectl;
            st   = m_haz(i, decRS) || (uses_rt(decInstrType) && m_haz(i, decRT));
            ectl = rst ? 4'b0011 : exBranchTaken ? 4'b1111 : st ? 4'b0001 : 4'b1100;
            if (armed) begin
                chk($sformatf("u%0d_ctl_c%0d", i, cyc), 16'(ctl[i]), 16'(ectl));
                chk($sformatf("u%0d_cnt_c%0d", i, cyc), cnt[i], 16'(m_cnt[i]));
                chk($sformatf("u%0d_err_c%0d", i, cyc), 16'(err[i]), 16'(m_err[i]));
            end
            if (rst) begin
                for (int r = 0; r < 32; r++) avail[i][r] = 0;
                m_cnt[i] = 0;
                m_run[i] = 0;
                m_err[i] = 0;
            end else begin
                if (!exBranchTaken && st) begin
                    if (m_cnt[i] < (1 << cw_of(i)) - 1) m_cnt[i]++;
                    m_run[i]++;
                    if (m_run[i] > ll_of(i)) m_err[i] = 1;
                end else begin
                    m_run[i] = 0;
                end
                if (exValid && exInstrType == 3'd2 && !(zr_of(i) != 0 && exRegDest == 5'd0))
                    avail[i][exRegDest] = cyc + ll_of(i);
            end
        end
        if (rst) armed = 1;
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic settle();
        #2;
    endtask
    task automatic ex(logic v, logic [2:0] t, logic [4:0] d, logic b);
        exValid = v;
        exInstrType = t;
        exRegDest = d;
        exBranchTaken = b;
    endtask
    task automatic dec(logic [2:0] t, logic [4:0] s, logic [4:0] r);
        decInstrType = t;
        decRS = s;
        decRT = r;
    endtask
    task automatic idle();
        ex(1'b0, 3'd0, 5'd0, 1'b0);
        dec(3'd1, 5'd0, 5'd0);
    endtask
    task automatic do_reset();
        step();
        rst = 1'b1;
        idle();
        settle();
        chk_ctl("rst_ctl", 0, 4'b0011);
        step();
        rst = 1'b0;
        settle();
        chk_cnt("rst_cnt", 0, 16'd0);
        chk_err("rst_err", 0, 1'b0);
    endtask

    initial begin
        do_reset();
        // LOAD_LAT=1 basics on u0.
        step(); ex(1, 3'd2, 5'd1, 0); dec(3'd0, 5'd1, 5'd2); settle();
        chk_ctl("ll1_rs_stall", 0, 4'b0001);
        step(); ex(0, 3'd0, 5'd0, 0); settle();
        chk_ctl("ll1_rs_release", 0, 4'b1100);
        step(); ex(1, 3'd2, 5'd1, 0); dec(3'd0, 5'd3, 5'd1); settle();
        chk_ctl("ll1_rt_stall", 0, 4'b0001);
        step(); ex(0, 3'd0, 5'd0, 0); settle();
        chk_ctl("ll1_rt_release", 0, 4'b1100);
        step(); ex(1, 3'd2, 5'd2, 0); dec(3'd0, 5'd1, 5'd1); settle();
        chk_ctl("ll1_other_dest", 0, 4'b1100);
        step(); ex(1, 3'd2, 5'd1, 0); dec(3'd1, 5'd2, 5'd1); settle();
        chk_ctl("ll1_aluimm_rt", 0, 4'b1100);
        step(); idle(); settle();
        chk_cnt("ll1_count", 0, 16'd2);
        chk_err("ll1_no_err", 0, 1'b0);

        // LOAD_LAT=3 countdown on u1, LOAD_LAT=4 on u2.
        do_reset();
        step(); ex(1, 3'd2, 5'd5, 0); dec(3'd4, 5'd0, 5'd5); settle();
        chk_ctl("ll3_stall0", 1, 4'b0001);
        step(); ex(0, 3'd0, 5'd0, 0); settle();
        chk_ctl("ll3_stall1", 1, 4'b0001);
        chk_ctl("ll1_release_t1", 0, 4'b1100);
        step(); settle();
        chk_ctl("ll3_stall2", 1, 4'b0001);
        step(); settle();
        chk_ctl("ll3_release", 1, 4'b1100);
        chk_cnt("ll3_count", 1, 16'd3);
        chk_err("ll3_no_err", 1, 1'b0);
        chk_ctl("ll4_stall3", 2, 4'b0001);

        // Taken branch overrides a stall and is not counted.
        do_reset();
        step(); ex(1, 3'd2, 5'd5, 1); dec(3'd0, 5'd5, 5'd0); settle();
        chk_ctl("br_over_stall", 0, 4'b1111);
        step(); idle(); settle();
        chk_cnt("br_no_count", 0, 16'd0);
        step(); ex(1, 3'd2, 5'd6, 0); dec(3'd0, 5'd6, 5'd0); settle();
        chk_ctl("ll3_pre_br", 1, 4'b0001);
        step(); ex(0, 3'd0, 5'd0, 1); settle();
        chk_ctl("ll3_br_flush", 1, 4'b1111);
        step(); ex(0, 3'd0, 5'd0, 0); settle();
        chk_ctl("ll3_after_br", 1, 4'b0001);
        step(); settle();
        chk_ctl("ll3_br_release", 1, 4'b1100);
        chk_cnt("ll3_br_count", 1, 16'd2);

        // Register 0 handling.
        do_reset();
        step(); ex(1, 3'd2, 5'd0, 0); dec(3'd0, 5'd0, 5'd0); settle();
        chk_ctl("zr_masked", 0, 4'b1100);
        chk_ctl("zr0_stall", 3, 4'b0001);
        step(); idle(); settle();
        chk_ctl("zr0_release", 3, 4'b1100);
        chk_cnt("zr0_count", 3, 16'd1);
        chk_cnt("zr_count", 0, 16'd0);

        // Reset in the middle of a LOAD_LAT=4 stall.
        do_reset();
        step(); ex(1, 3'd2, 5'd5, 0); dec(3'd0, 5'd5, 5'd0); settle();
        chk_ctl("ll4_stall0", 2, 4'b0001);
        step(); rst = 1'b1; ex(0, 3'd0, 5'd0, 0); settle();
        chk_ctl("rst_mid_stall", 2, 4'b0011);
        step(); rst = 1'b0; settle();
        chk_ctl("rst_cleared", 2, 4'b1100);
        chk_cnt("rst_cleared_cnt", 2, 16'd0);

        // Twenty back-to-back stalls: saturation and watchdog.
        do_reset();
        step(); ex(1, 3'd2, 5'd5, 0); dec(3'd0, 5'd5, 5'd0);
        repeat (19) step();
        step(); idle(); settle();
        chk_cnt("sat_cnt4", 3, 16'd15);
        chk_err("wd_err_u3", 3, 1'b1);
        chk_cnt("cnt16", 0, 16'd20);
        chk_err("wd_err_u0", 0, 1'b1);
        chk_err("wd_err_u1", 1, 1'b1);
        repeat (3) step();
        settle();
        chk_err("wd_sticky", 3, 1'b1);
        do_reset();
        chk_err("wd_cleared", 3, 1'b0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
